// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states,
// default latency and the byte-enable helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int unsigned DEFAULT_LATENCY = 2;

  function automatic logic [3:0] byteEnable(input size_e size, input logic [1:0] lane);
    logic [3:0] be;
    be = '0;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = '1;
      default: be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data array with per-byte write enables and a registered read port.
module dmem_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with programmable wait states,
// byte/half/word lane handling and load extension.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_sign,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  state_e      state;
  logic [3:0]  waitCnt;
  logic        reqWe;
  size_e       reqSize;
  logic        reqSign;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;

  logic [1:0]        lane;
  logic [ADDR_W-1:0] ramAddr;
  logic [3:0]        ramBe;
  logic [31:0]       ramWdata;
  logic [31:0]       ramRdata;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [31:0]       loadData;
  logic              reqErr;
  logic              accessNow;

  assign lane = reqAddr[1:0];

  // The array read is issued from the live request address while idle and
  // from the latched address afterwards, so the registered read is always
  // one cycle ahead of the access edge, even with zero wait states.
  assign ramAddr   = (state == S_IDLE) ? i_req_addr[ADDR_W+1:2] : reqAddr[ADDR_W+1:2];
  assign accessNow = (state == S_WAIT) && (waitCnt == '0);

  always_comb begin
    reqErr = 1'b0;
    case (reqSize)
      SZ_BYTE: reqErr = 1'b0;
      SZ_HALF: reqErr = lane[0];
      SZ_WORD: reqErr = (lane != 2'b00);
      default: reqErr = 1'b1;
    endcase
    if ((reqAddr >> (ADDR_W + 2)) != '0) reqErr = 1'b1;
  end

  always_comb begin
    case (reqSize)
      SZ_BYTE: ramWdata = {4{reqWdata[7:0]}};
      SZ_HALF: ramWdata = {2{reqWdata[15:0]}};
      default: ramWdata = reqWdata;
    endcase
    ramBe = (accessNow && reqWe && !reqErr) ? byteEnable(reqSize, lane) : '0;
  end

  always_comb begin
    byteSel = ramRdata[{lane, 3'b000} +: 8];
    halfSel = lane[1] ? ramRdata[31:16] : ramRdata[15:0];
    case (reqSize)
      SZ_BYTE: loadData = {{24{reqSign & byteSel[7]}}, byteSel};
      SZ_HALF: loadData = {{16{reqSign & halfSel[15]}}, halfSel};
      default: loadData = ramRdata;
    endcase
  end

  dmem_ram #(.ADDR_W(ADDR_W)) uRam (
    .clk   (clk),
    .be    (ramBe),
    .addr  (ramAddr),
    .wdata (ramWdata),
    .rdata (ramRdata)
  );

  // WAIT spans LATENCY+1 cycles: the counter counts down to zero and the
  // access happens on the zero cycle, absorbing the array's read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      waitCnt     <= '0;
      reqWe       <= 1'b0;
      reqSize     <= SZ_BYTE;
      reqSign     <= 1'b0;
      reqAddr     <= '0;
      reqWdata    <= '0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            reqWe       <= i_req_we;
            reqSize     <= size_e'(i_req_size);
            reqSign     <= i_req_sign;
            reqAddr     <= i_req_addr;
            reqWdata    <= i_req_wdata;
            waitCnt     <= 4'(LATENCY);
            o_req_ready <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (waitCnt == '0) begin
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= reqErr;
            o_rsp_rdata <= (reqErr || reqWe) ? '0 : loadData;
            state       <= S_RESP;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_req_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0
// instance sharing clock, reset and request payload.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqWe = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic        reqSign = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;

  logic        reqValidA = 1'b0, rspReadyA = 1'b0;
  logic        reqReadyA, rspValidA, rspErrA;
  logic [31:0] rspRdataA;

  logic        reqValid0 = 1'b0, rspReady0 = 1'b1;
  logic        reqReady0, rspValid0, rspErr0;
  logic [31:0] rspRdata0;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) dutA (
    .clk(clk), .rst(rst),
    .i_req_valid(reqValidA), .o_req_ready(reqReadyA),
    .i_req_we(reqWe), .i_req_size(reqSize), .i_req_sign(reqSign),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_rsp_valid(rspValidA), .i_rsp_ready(rspReadyA),
    .o_rsp_rdata(rspRdataA), .o_rsp_err(rspErrA)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .i_req_valid(reqValid0), .o_req_ready(reqReady0),
    .i_req_we(reqWe), .i_req_size(reqSize), .i_req_sign(reqSign),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_rsp_valid(rspValid0), .i_rsp_ready(rspReady0),
    .o_rsp_rdata(rspRdata0), .o_rsp_err(rspErr0)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request on the selected instance, report response and the
  // number of edges from acceptance to o_rsp_valid, then hand it off.
  task automatic doTxn(input bit z, input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    bit   accepted;
    logic rdy;
    reqWe = we; reqSize = size; reqSign = sign; reqAddr = addr; reqWdata = wdata;
    if (z) reqValid0 = 1'b1; else reqValidA = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      rdy = z ? reqReady0 : reqReadyA;
      @(posedge clk); #1;
      if (rdy) accepted = 1'b1;
    end
    reqValidA = 1'b0; reqValid0 = 1'b0;
    if (!accepted) checkVal("accept_timeout", 32'd0, 32'd1);
    lat = 0;
    while (!(z ? rspValid0 : rspValidA) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = z ? rspRdata0 : rspRdataA;
    err   = z ? rspErr0 : rspErrA;
    if (!z) rspReadyA = 1'b1;
    @(posedge clk); #1;
    rspReadyA = 1'b0;
  endtask

  task automatic runCheck(input bit z, input string tag, input logic we, input logic [1:0] size,
                          input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] expRdata, input logic expErr);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    doTxn(z, we, size, sign, addr, wdata, rdata, err, lat);
    checkVal({tag, ".rdata"}, rdata, expRdata);
    checkVal({tag, ".err"}, {31'd0, err}, {31'd0, expErr});
    checkVal({tag, ".lat"}, lat, z ? 32'd1 : 32'd3);
  endtask

  logic [31:0] held;

  initial begin
    #12 rst = 1'b0;
    #1;
    checkVal("rst.reqReady", {31'd0, reqReadyA}, 32'd1);
    checkVal("rst.rspValid", {31'd0, rspValidA}, 32'd0);
    checkVal("rst.rdata", rspRdataA, 32'd0);
    checkVal("rst.err", {31'd0, rspErrA}, 32'd0);
    checkVal("rst0.reqReady", {31'd0, reqReady0}, 32'd1);

    runCheck(0, "stW10",   1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    runCheck(0, "ldW10",   0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    runCheck(0, "stW10b",  1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0);
    runCheck(0, "stB13",   1, 2'b00, 0, 32'h13, 32'h00000080, 32'h0, 0);
    runCheck(0, "ldSB13",  0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    runCheck(0, "ldUB13",  0, 2'b00, 0, 32'h13, 32'h0, 32'h00000080, 0);
    runCheck(0, "ldW10c",  0, 2'b10, 0, 32'h10, 32'h0, 32'h80223344, 0);
    runCheck(0, "ldSB11",  0, 2'b00, 1, 32'h11, 32'h0, 32'h00000033, 0);
    runCheck(0, "ldSH12",  0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFF8022, 0);
    runCheck(0, "ldUH10",  0, 2'b01, 0, 32'h10, 32'h0, 32'h00003344, 0);
    runCheck(0, "ldH11",   0, 2'b01, 1, 32'h11, 32'h0, 32'h0, 1);
    runCheck(0, "stW12",   1, 2'b10, 0, 32'h12, 32'h55555555, 32'h0, 1);
    runCheck(0, "ldW10d",  0, 2'b10, 0, 32'h10, 32'h0, 32'h80223344, 0);
    runCheck(0, "sz11",    0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
    runCheck(0, "oob1000", 0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1);

    // Back-pressure: response held while a second request waits.
    reqWe = 0; reqSize = 2'b10; reqSign = 0; reqAddr = 32'h10; reqValidA = 1'b1;
    @(posedge clk); #1;
    reqValidA = 1'b0;
    for (int i = 0; i < 50 && !rspValidA; i++) begin @(posedge clk); #1; end
    checkVal("bp.valid", {31'd0, rspValidA}, 32'd1);
    held = rspRdataA;
    checkVal("bp.rdata", held, 32'h80223344);
    reqWe = 1; reqAddr = 32'h14; reqWdata = 32'hA5A5A5A5; reqValidA = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkVal("bp.holdValid", {31'd0, rspValidA}, 32'd1);
      checkVal("bp.holdRdata", rspRdataA, 32'h80223344);
      checkVal("bp.holdReady", {31'd0, reqReadyA}, 32'd0);
    end
    rspReadyA = 1'b1;
    @(posedge clk); #1;
    rspReadyA = 1'b0;
    checkVal("bp.afterHsValid", {31'd0, rspValidA}, 32'd0);
    checkVal("bp.afterHsReady", {31'd0, reqReadyA}, 32'd1);
    @(posedge clk); #1;
    reqValidA = 1'b0;
    checkVal("bp.acceptedNext", {31'd0, reqReadyA}, 32'd0);
    for (int i = 0; i < 50 && !rspValidA; i++) begin @(posedge clk); #1; end
    checkVal("bp.st14err", {31'd0, rspErrA}, 32'd0);
    rspReadyA = 1'b1;
    @(posedge clk); #1;
    rspReadyA = 1'b0;
    runCheck(0, "ldW14", 0, 2'b10, 0, 32'h14, 32'h0, 32'hA5A5A5A5, 0);

    // Reset during the wait states of a store: the store must be dropped.
    runCheck(0, "stW20z", 1, 2'b10, 0, 32'h20, 32'h00000000, 32'h0, 0);
    reqWe = 1; reqSize = 2'b10; reqAddr = 32'h20; reqWdata = 32'h12345678; reqValidA = 1'b1;
    @(posedge clk); #1;
    reqValidA = 1'b0;
    checkVal("rw.inWait", {31'd0, reqReadyA}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkVal("rw.reqReady", {31'd0, reqReadyA}, 32'd1);
    checkVal("rw.rspValid", {31'd0, rspValidA}, 32'd0);
    checkVal("rw.rdata", rspRdataA, 32'd0);
    checkVal("rw.err", {31'd0, rspErrA}, 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    runCheck(0, "ldW20", 0, 2'b10, 0, 32'h20, 32'h0, 32'h00000000, 0);
    runCheck(0, "ldW10e", 0, 2'b10, 0, 32'h10, 32'h0, 32'h80223344, 0);

    // Zero-wait-state instance with the response channel always ready.
    runCheck(1, "z.stW40",  1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0);
    runCheck(1, "z.ldW40",  0, 2'b10, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0);
    runCheck(1, "z.stB41",  1, 2'b00, 0, 32'h41, 32'h0000005A, 32'h0, 0);
    runCheck(1, "z.ldW40b", 0, 2'b10, 0, 32'h40, 32'h0, 32'hCAFE5A0D, 0);
    runCheck(1, "z.ldSH42", 0, 2'b01, 1, 32'h42, 32'h0, 32'hFFFFCAFE, 0);
    runCheck(1, "z.ldUB43", 0, 2'b00, 0, 32'h43, 32'h0, 32'h000000CA, 0);
    runCheck(1, "z.ldW42",  0, 2'b10, 0, 32'h42, 32'h0, 32'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
